// File: rtl/mips_pkg.sv
// Shared definitions for the 5-stage MIPS pipeline.
//   - NOP instruction encoding used to flush the IF/ID register
//   - Primary opcode constants (bits [31:26] of the instruction word)
//   - Fetch/decode FSM state enum
package mips_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    localparam logic [5:0] OP_ALU     = 6'h00;  // R-type, function in [5:0]
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_ADD_IMM = 6'h08;
    localparam logic [5:0] OP_LW      = 6'h23;

    typedef enum logic [1:0] {
        ST_BOOT     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STALL    = 2'd2,
        ST_WAIT_MEM = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/if_id_stall_monitor.sv
// Stall statistics for the fetch/decode boundary.
// Ports:
//   clock, reset_n  pipeline clock / asynchronous active-low reset
//   stall_in        interlock stall request this cycle
//   stall_count     total stall cycles since reset, saturating at all-ones
//   stall_timeout   sticky flag: a run of consecutive stalls reached MAX_STALL
module stall_monitor #(
    parameter int MAX_STALL = 8,
    parameter int CNT_W     = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             stall_in,
    output logic [CNT_W-1:0] stall_count,
    output logic             stall_timeout
);

    // The run counter only needs to reach MAX_STALL; it parks there.
    localparam int RUN_W = $clog2(MAX_STALL + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_STALL);

    logic [CNT_W-1:0] count_q, count_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic             timeout_q, timeout_d;

    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        count_d   = count_q;
        run_d     = run_q;
        timeout_d = timeout_q;
        if (stall_in) begin
            if (count_q != '1) count_d = count_q + CNT_W'(1);
            if (run_q != RUN_MAX) run_d = run_q + RUN_W'(1);
            if (run_d == RUN_MAX) timeout_d = 1'b1;
        end else begin
            run_d = '0;
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q   <= '0;
            run_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            run_q     <= run_d;
            timeout_q <= timeout_d;
        end
    end

    assign stall_count   = count_q;
    assign stall_timeout = timeout_q;

endmodule

// File: rtl/if_id_stage.sv
// Fetch/decode boundary of the 5-stage MIPS pipeline.
// Owns the fetch PC and the IF/ID register (IR, PC+4, valid). Freezes on an
// interlock stall (and bubbles ID/EX), squashes the fetched-behind instruction
// on a taken BEQ, and inserts NOPs while instruction memory is not ready.
// Ports:
//   clock, reset_n         pipeline clock / asynchronous active-low reset
//   stall_in               interlock stall request for the instruction in ID
//   branch_taken           BEQ in ID resolved taken this cycle
//   branch_target          target PC for a taken branch
//   imem_instr, imem_valid instruction word at pc_out and its valid flag
//   pc_out                 current fetch PC
//   ifid_ir/pc4/valid      IF/ID pipeline register
//   idex_bubble            force ID/EX controls to NOP (combinational)
//   stall_count            saturating total stall cycles
//   stall_timeout          sticky stuck-stall flag
module if_id_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MAX_STALL = 8,
    parameter int          CNT_W     = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             stall_in,
    input  logic             branch_taken,
    input  logic [31:0]      branch_target,
    input  logic [31:0]      imem_instr,
    input  logic             imem_valid,
    output logic [31:0]      pc_out,
    output logic [31:0]      ifid_ir,
    output logic [31:0]      ifid_pc4,
    output logic             ifid_valid,
    output logic             idex_bubble,
    output logic [CNT_W-1:0] stall_count,
    output logic             stall_timeout
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  ir_q, ir_d;
    logic [31:0]  pc4_q, pc4_d;
    logic         valid_q, valid_d;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        case (state_q)
            ST_BOOT: begin
                ir_d    = NOP_INSTR;
                valid_d = 1'b0;
                state_d = ST_RUN;
            end
            default: begin
                if (stall_in) begin
                    // Branch is ignored: its operands are not forwarded yet.
                    state_d = ST_STALL;
                end else if (branch_taken) begin
                    pc_d    = branch_target;
                    ir_d    = NOP_INSTR;
                    valid_d = 1'b0;
                    state_d = ST_RUN;
                end else if (!imem_valid) begin
                    ir_d    = NOP_INSTR;
                    valid_d = 1'b0;
                    state_d = ST_WAIT_MEM;
                end else begin
                    // 32-bit adds wrap naturally from FFFF_FFFC to 0.
                    ir_d    = imem_instr;
                    pc4_d   = pc_q + 32'd4;
                    valid_d = 1'b1;
                    pc_d    = pc_q + 32'd4;
                    state_d = ST_RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            ir_q    <= NOP_INSTR;
            pc4_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

    assign pc_out      = pc_q;
    assign ifid_ir     = ir_q;
    assign ifid_pc4    = pc4_q;
    assign ifid_valid  = valid_q;
    // Straight from the input so the bubble lands in the same cycle as the stall.
    assign idex_bubble = stall_in | (state_q == ST_BOOT);

    stall_monitor #(
        .MAX_STALL (MAX_STALL),
        .CNT_W     (CNT_W)
    ) u_stall_monitor (
        .clock         (clock),
        .reset_n       (reset_n),
        .stall_in      (stall_in),
        .stall_count   (stall_count),
        .stall_timeout (stall_timeout)
    );

endmodule

// File: tb/tb_if_id_stage.sv
// Scoreboard bench for if_id_stage. A driver steps a behavioural model once per
// clock and queues the expected outputs; a monitor pops and compares at negedge.
module tb_if_id_stage;
    import mips_pkg::*;

    localparam int          CNT_W     = 6;
    localparam int          MAX_STALL = 8;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam int          CNT_MAX   = (1 << CNT_W) - 1;

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic             stall_in = 1'b0;
    logic             branch_taken = 1'b0;
    logic [31:0]      branch_target = '0;
    logic [31:0]      imem_instr = '0;
    logic             imem_valid = 1'b0;
    logic [31:0]      pc_out, ifid_ir, ifid_pc4;
    logic             ifid_valid, idex_bubble, stall_timeout;
    logic [CNT_W-1:0] stall_count;

    if_id_stage #(.RESET_PC(RESET_PC), .MAX_STALL(MAX_STALL), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset_n(reset_n), .stall_in(stall_in),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .imem_instr(imem_instr), .imem_valid(imem_valid),
        .pc_out(pc_out), .ifid_ir(ifid_ir), .ifid_pc4(ifid_pc4),
        .ifid_valid(ifid_valid), .idex_bubble(idex_bubble),
        .stall_count(stall_count), .stall_timeout(stall_timeout)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] pc, ir, pc4;
        logic        valid, bubble, timeout;
        int          count;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // ---------------- behavioural model ----------------
    logic [31:0] m_pc, m_ir, m_pc4;
    logic        m_valid, m_boot, m_timeout;
    int          m_count, m_run;

    function automatic void model_reset();
        m_pc = RESET_PC; m_ir = NOP_INSTR; m_pc4 = '0; m_valid = 1'b0;
        m_boot = 1'b1; m_count = 0; m_run = 0; m_timeout = 1'b0;
    endfunction

    // Advance one clock using the inputs that were applied before the edge.
    function automatic void model_step();
        if (!reset_n) begin
            model_reset();
            return;
        end
        if (stall_in) begin
            m_count = (m_count == CNT_MAX) ? CNT_MAX : m_count + 1;
            m_run++;
            if (m_run >= MAX_STALL) m_timeout = 1'b1;
        end else begin
            m_run = 0;
        end
        if (m_boot) begin
            m_boot = 1'b0;
        end else if (stall_in) begin
            // frozen
        end else if (branch_taken) begin
            m_pc = branch_target; m_ir = NOP_INSTR; m_valid = 1'b0;
        end else if (!imem_valid) begin
            m_ir = NOP_INSTR; m_valid = 1'b0;
        end else begin
            m_ir = imem_instr; m_pc4 = m_pc + 32'd4; m_valid = 1'b1; m_pc = m_pc + 32'd4;
        end
    endfunction

    task automatic cycle(input logic rl, input logic st, input logic br,
                         input logic [31:0] tgt, input logic iv, input logic [31:0] instr);
        exp_t e;
        @(posedge clock);
        #2;
        model_step();
        reset_n = rl; stall_in = st; branch_taken = br;
        branch_target = tgt; imem_valid = iv; imem_instr = instr;
        if (!rl) model_reset();
        e.pc = m_pc; e.ir = m_ir; e.pc4 = m_pc4; e.valid = m_valid;
        e.bubble = st | m_boot; e.timeout = m_timeout; e.count = m_count;
        q.push_back(e);
    endtask

    function automatic logic [31:0] lw_at(input logic [31:0] pc);
        return {OP_LW, 5'd0, 5'd1, pc[15:0]};
    endfunction

    task automatic fetch(input int n);
        for (int i = 0; i < n; i++) cycle(1, 0, 0, 0, 1, lw_at(m_pc));
    endtask

    task automatic stall(input int n, input logic br);
        for (int i = 0; i < n; i++) cycle(1, 1, br, 32'h40, 1, lw_at(m_pc));
    endtask

    // ---------------- monitor ----------------
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("pc_out", pc_out, e.pc);
                chk("ifid_ir", ifid_ir, e.ir);
                chk("ifid_pc4", ifid_pc4, e.pc4);
                chk("ifid_valid", 32'(ifid_valid), 32'(e.valid));
                chk("idex_bubble", 32'(idex_bubble), 32'(e.bubble));
                chk("stall_count", 32'(stall_count), 32'(e.count));
                chk("stall_timeout", 32'(stall_timeout), 32'(e.timeout));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic st, br, iv, rl;
        model_reset();
        // 1. reset, boot, fetches from 0
        cycle(0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 1, lw_at(0));   // release; next edge is BOOT
        fetch(3);                          // pc 0 -> 4 -> 8 -> C
        // 2. two-cycle stall at PC=8 region, then continue to 0x10
        stall(2, 0);
        fetch(1);
        // 3. taken branch to 0x40, then fetch resumes at 0x44
        cycle(1, 0, 1, 32'h40, 1, lw_at(m_pc));
        fetch(2);
        // 4. stall and branch together: stall wins, branch on first free cycle
        stall(2, 1);
        cycle(1, 0, 1, 32'h80, 1, lw_at(m_pc));
        fetch(1);
        // 5. three cycles of imem not ready
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 0, 32'hDEAD_BEEF);
        fetch(2);
        // 6. eight-cycle stall trips the timeout, stays sticky
        stall(8, 0);
        fetch(3);
        cycle(0, 0, 0, 0, 1, 0);           // reset pulse clears it
        cycle(1, 0, 0, 0, 1, lw_at(0));
        fetch(1);
        stall(5, 0);
        cycle(0, 1, 0, 0, 1, 0);           // reset mid-stall
        cycle(1, 1, 0, 0, 1, lw_at(0));
        stall(7, 0);
        fetch(1);
        // PC wrap from FFFF_FFFC to 0
        cycle(1, 0, 1, 32'hFFFF_FFFC, 1, 0);
        fetch(3);
        // randomized traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            rl = ($urandom_range(0, 99) != 0);
            st = ($urandom_range(0, 9) < 3);
            br = ($urandom_range(0, 9) < 2);
            iv = ($urandom_range(0, 9) > 1);
            cycle(rl, st, br, $urandom() & 32'hFFFF_FFFC, iv, $urandom());
        end
        // drain the scoreboard with a bounded wait
        for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clock);
        #1;
        n_checks++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL drain: %0d entries left, expected 0", q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
